sprite_attr_commit_ctrl: RTL and testbench

Tear-free scheduler for the sprite engine's attribute write port (spr_wr_en/idx/data).
- Host (Avalon slave decode) writes go into a NUM_SPRITE×32 shadow array with per-entry dirty bits.
- On host request, dirty entries are copied into the engine's attribute RAM only during vertical blank (vcount 480–524), so attributes never change mid-frame.
- Sits between the bus interface and sprite_engine; it is the sole driver of the engine's attribute write port.

---
 rtl/sprite_attr_commit_ctrl_if.sv | 37 +++
 rtl/sprite_attr_commit_ctrl.sv | 144 ++++++++++++++
 tb/tb_sprite_attr_commit_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_attr_commit_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sprite_attr_commit_ctrl_if
// Brief  : Host shadow-access bus and sprite-engine attribute write port.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface sprite_attr_commit_ctrl_if #(
    parameter int NUM_SPRITE = 32
);
    localparam int IW = $clog2(NUM_SPRITE);

    logic          host_wr_en;
    logic [IW-1:0] host_wr_idx;
    logic [31:0]   host_wr_data;
    logic [IW-1:0] host_rd_idx;
    logic [31:0]   host_rd_data;
    logic          host_commit;
    logic          commit_pending;
    logic          commit_busy;
    logic          commit_done;
    logic          spr_wr_en;
    logic [IW-1:0] spr_wr_idx;
    logic [31:0]   spr_wr_data;

    modport master (
        output host_wr_en, host_wr_idx, host_wr_data, host_rd_idx, host_commit,
        input  host_rd_data, commit_pending, commit_busy, commit_done,
        input  spr_wr_en, spr_wr_idx, spr_wr_data
    );

    modport slave (
        input  host_wr_en, host_wr_idx, host_wr_data, host_rd_idx, host_commit,
        output host_rd_data, commit_pending, commit_busy, commit_done,
        output spr_wr_en, spr_wr_idx, spr_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/sprite_attr_commit_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sprite_attr_commit_ctrl
// Brief  : Shadowed sprite attributes, copied to the engine only in vblank.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module sprite_attr_commit_ctrl #(
    parameter int NUM_SPRITE = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [9:0]            vcount,
    sprite_attr_commit_ctrl_if.slave   bus
);
    localparam int IW = $clog2(NUM_SPRITE);
    localparam logic [IW-1:0] c_last_idx   = IW'(NUM_SPRITE - 1);
    localparam logic [9:0]    c_vblank_top = 10'd480;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_VBL = 2'd1,
        S_SCAN     = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_shadow [NUM_SPRITE];
    logic [NUM_SPRITE-1:0] r_dirty;
    logic [IW-1:0]   r_scan_idx;
    logic [IW-1:0]   w_scan_idx_nxt;
    logic            r_recommit;
    logic            w_recommit_nxt;
    logic            w_in_vblank;
    logic            w_visit;
    logic            w_copy;
    logic            w_done;

    logic            r_spr_wr_en;
    logic [IW-1:0]   r_spr_wr_idx;
    logic [31:0]     r_spr_wr_data;
    logic            r_commit_done;

    assign w_in_vblank = (vcount >= c_vblank_top);

    always_comb begin
        w_state_nxt    = r_state;
        w_scan_idx_nxt = r_scan_idx;
        w_recommit_nxt = r_recommit;
        w_visit        = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.host_commit) begin
                    w_state_nxt = S_WAIT_VBL;
                end
            end
            S_WAIT_VBL: begin
                if (w_in_vblank) begin
                    w_state_nxt    = S_SCAN;
                    w_scan_idx_nxt = '0;
                end
            end
            S_SCAN: begin
                // Leaving vblank aborts; the pending request stays and restarts at 0.
                if (!w_in_vblank) begin
                    w_state_nxt    = S_WAIT_VBL;
                    w_recommit_nxt = 1'b0;
                end else begin
                    w_visit = 1'b1;
                    if (bus.host_commit) begin
                        w_recommit_nxt = 1'b1;
                    end
                    if (r_scan_idx == c_last_idx) begin
                        w_done         = 1'b1;
                        w_recommit_nxt = 1'b0;
                        w_state_nxt    = (r_recommit || bus.host_commit) ? S_WAIT_VBL : S_IDLE;
                    end else begin
                        w_scan_idx_nxt = r_scan_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_copy = w_visit & r_dirty[r_scan_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_scan_idx <= '0;
            r_recommit <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_scan_idx <= w_scan_idx_nxt;
            r_recommit <= w_recommit_nxt;
        end
    end

    // Host set is ordered after the scan clear so a same-cycle write stays dirty.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITE; i++) begin
                r_shadow[i] <= 32'd0;
            end
            r_dirty <= '1;
        end else begin
            if (w_copy) begin
                r_dirty[r_scan_idx] <= 1'b0;
            end
            if (bus.host_wr_en) begin
                r_shadow[bus.host_wr_idx] <= bus.host_wr_data;
                r_dirty[bus.host_wr_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spr_wr_en   <= 1'b0;
            r_spr_wr_idx  <= '0;
            r_spr_wr_data <= 32'd0;
            r_commit_done <= 1'b0;
        end else begin
            r_spr_wr_en   <= w_copy;
            r_commit_done <= w_done;
            if (w_copy) begin
                r_spr_wr_idx  <= r_scan_idx;
                r_spr_wr_data <= r_shadow[r_scan_idx];
            end
        end
    end

    assign bus.host_rd_data   = r_shadow[bus.host_rd_idx];
    assign bus.commit_pending = (r_state != S_IDLE);
    assign bus.commit_busy    = (r_state == S_SCAN);
    assign bus.commit_done    = r_commit_done;
    assign bus.spr_wr_en      = r_spr_wr_en;
    assign bus.spr_wr_idx     = r_spr_wr_idx;
    assign bus.spr_wr_data    = r_spr_wr_data;
endmodule
`default_nettype wire

// File: tb/tb_sprite_attr_commit_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_sprite_attr_commit_ctrl
// Brief  : Directed + random bench against a cycle-level reference model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_sprite_attr_commit_ctrl;
    localparam int N = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] vcount;

    always #5 clk = ~clk;

    sprite_attr_commit_ctrl_if #(.NUM_SPRITE(N)) bus ();

    sprite_attr_commit_ctrl #(.NUM_SPRITE(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .vcount (vcount),
        .bus    (bus.slave)
    );

    // Reference model: 0 idle, 1 waiting for vblank, 2 scanning
    int          m_phase;
    int          m_pos;
    bit          m_again;
    logic [31:0] m_sh [N];
    bit          m_dt [N];
    bit          m_en;
    int          m_idx;
    logic [31:0] m_data;
    bit          m_done;

    int tests = 0;
    int fails = 0;
    int n_wr;
    int n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit vb;
        bit nen;
        bit ndone;
        vb    = (vcount >= 10'd480);
        nen   = 1'b0;
        ndone = 1'b0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_sh[i] = 32'd0;
                m_dt[i] = 1'b1;
            end
            m_phase = 0; m_pos = 0; m_again = 0;
            m_idx = 0; m_data = 32'd0;
        end else begin
            if (m_phase == 0) begin
                if (bus.host_commit) m_phase = 1;
            end else if (m_phase == 1) begin
                if (vb) begin m_phase = 2; m_pos = 0; end
            end else begin
                if (!vb) begin
                    m_phase = 1; m_again = 0;
                end else begin
                    if (bus.host_commit) m_again = 1;
                    if (m_dt[m_pos]) begin
                        nen = 1; m_idx = m_pos; m_data = m_sh[m_pos]; m_dt[m_pos] = 0;
                    end
                    if (m_pos == N - 1) begin
                        ndone = 1;
                        m_phase = m_again ? 1 : 0;
                        m_again = 0;
                    end else begin
                        m_pos++;
                    end
                end
            end
            if (bus.host_wr_en) begin
                m_sh[bus.host_wr_idx] = bus.host_wr_data;
                m_dt[bus.host_wr_idx] = 1'b1;
            end
        end
        m_en   = nen;
        m_done = ndone;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("spr_wr_en", {31'd0, bus.spr_wr_en}, {31'd0, m_en});
        if (m_en) begin
            chk("spr_wr_idx", {27'd0, bus.spr_wr_idx}, m_idx);
            chk("spr_wr_data", bus.spr_wr_data, m_data);
        end
        chk("commit_done", {31'd0, bus.commit_done}, {31'd0, m_done});
        chk("commit_pending", {31'd0, bus.commit_pending}, (m_phase != 0) ? 32'd1 : 32'd0);
        chk("commit_busy", {31'd0, bus.commit_busy}, (m_phase == 2) ? 32'd1 : 32'd0);
        chk("host_rd_data", bus.host_rd_data, m_sh[bus.host_rd_idx]);
        if (m_en) n_wr++;
        if (m_done) n_done++;
        bus.host_wr_en  = 1'b0;
        bus.host_commit = 1'b0;
        bus.host_rd_idx = 5'($urandom_range(0, N - 1));
    endtask

    task automatic run(input int n, input int vc);
        vcount = 10'(vc);
        repeat (n) tick();
    endtask

    task automatic host_write(input int idx, input logic [31:0] data);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_idx  = 5'(idx);
        bus.host_wr_data = data;
        tick();
    endtask

    task automatic commit();
        bus.host_commit = 1'b1;
        tick();
    endtask

    // Advance until the model is about to visit index p in a scan
    task automatic run_until_pos(input int p, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_phase == 2 && m_pos == p) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("reach_scan_pos", {31'd0, found}, 32'd1);
    endtask

    task automatic clear_counts();
        n_wr   = 0;
        n_done = 0;
    endtask

    initial begin
        reset            = 1'b1;
        vcount           = 10'd100;
        bus.host_wr_en   = 1'b0;
        bus.host_wr_idx  = '0;
        bus.host_wr_data = 32'd0;
        bus.host_rd_idx  = '0;
        bus.host_commit  = 1'b0;
        clear_counts();

        // Reset state
        tick(); tick();
        chk("rst_spr_wr_idx", {27'd0, bus.spr_wr_idx}, 32'd0);
        chk("rst_spr_wr_data", bus.spr_wr_data, 32'd0);
        reset = 1'b0;

        // First commit copies zeros everywhere, only once vblank starts
        vcount = 10'd100;
        clear_counts();
        commit();
        run(10, 100);
        chk("no_write_active", n_wr, 0);
        run(40, 480);
        chk("first_commit_writes", n_wr, 32);
        chk("first_commit_done", n_done, 1);

        // Two dirty entries only
        host_write(3, 32'h8000_1234);
        host_write(17, 32'hC123_4501);
        clear_counts();
        commit();
        run(40, 480);
        chk("two_writes", n_wr, 2);
        chk("two_done", n_done, 1);

        // Host write colliding with the scan visit of the same entry
        host_write(5, 32'h1);
        clear_counts();
        commit();
        run_until_pos(5, 20);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_idx  = 5'd5;
        bus.host_wr_data = 32'hA;
        tick();
        run(40, 480);
        chk("collide_first", n_wr, 1);
        clear_counts();
        commit();
        run(40, 480);
        chk("collide_second", n_wr, 1);

        // Vblank ends mid-scan, then restart
        vcount = 10'd300;
        for (int i = 0; i < N; i++) host_write(i, $urandom);
        clear_counts();
        commit();
        vcount = 10'd524;
        run_until_pos(10, 20);
        chk("abort_before", n_wr, 10);
        run(20, 0);
        chk("abort_stalled", n_wr, 10);
        clear_counts();
        run(40, 480);
        chk("abort_resume", n_wr, 22);
        chk("abort_done", n_done, 1);

        // Re-commit during scan
        host_write(7, $urandom);
        host_write(9, $urandom);
        clear_counts();
        commit();
        run_until_pos(15, 20);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_idx  = 5'd2;
        bus.host_wr_data = $urandom;
        bus.host_commit  = 1'b1;
        tick();
        run(80, 480);
        chk("recommit_writes", n_wr, 3);
        chk("recommit_done", n_done, 2);

        // Reset mid-scan, with a commit in the same cycle
        for (int i = 0; i < N; i++) host_write(i, $urandom);
        commit();
        run_until_pos(8, 20);
        reset = 1'b1;
        bus.host_commit = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_idx", {27'd0, bus.spr_wr_idx}, 32'd0);
        chk("rst_mid_data", bus.spr_wr_data, 32'd0);
        run(5, 480);
        clear_counts();
        commit();
        run(40, 480);
        chk("post_reset_writes", n_wr, 32);

        // Random traffic with a slowly advancing raster
        vcount = 10'd400;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
            if ($urandom_range(0, 5) == 0) begin
                bus.host_wr_en   = 1'b1;
                bus.host_wr_idx  = 5'($urandom_range(0, N - 1));
                bus.host_wr_data = $urandom;
            end
            if ($urandom_range(0, 40) == 0) bus.host_commit = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
